aes_128_sched: RTL and testbench
================================

AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 Parameter: TAG_DEPTH, 16, depth of the in-flight channel-tag FIFO, power of two, 4..64.
REQ-002 Parameter: NUM_RKEYS, 11, number of 128-bit round keys loaded per key schedule.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: kill  input  1  asynchronous, active-high reset.
REQ-005 Port: key_in / key_valid / key_ready  in/in/out  128/1/1  round-key stream from host, valid/ready handshake.
REQ-006 Port: req0_data / req0_valid / req0_ready  in/in/out  128/1/1  channel 0 plaintext block request.
REQ-007 Port: req1_data / req1_valid / req1_ready  in/in/out  128/1/1  channel 1 plaintext block request.
REQ-008 Port: core_in_data / core_in_en  out/out  128/1  block to AES core; one-cycle strobe.
REQ-009 Port: core_en_wr / core_addr_wr / core_key_wr  out/out/out  1/5/64  key RAM write port.
REQ-010 Port: core_out_data / core_out_en  in/in  128/1  AES core result; one-cycle strobe, results in issue order.
REQ-011 Port: rsp0_data / rsp0_valid, rsp1_data / rsp1_valid  out  128/1 each  routed result per channel; no backpressure.
REQ-012 Port: keys_loaded / busy / err_unexp  out/out/out  1/1/1  status flags.

Function
REQ-013 FSM states SHALL be KEY_WAIT, KEY_WR_LO, KEY_WR_HI, RUN.
REQ-014 KEY_WAIT: key_ready=1; on key_valid&key_ready capture key_in, go KEY_WR_LO.
REQ-015 KEY_WR_LO: core_en_wr=1, core_addr_wr=2*k, core_key_wr=key[63:0]; go KEY_WR_HI.
REQ-016 KEY_WR_HI: core_en_wr=1, core_addr_wr=2*k+1, core_key_wr=key[127:64]; k increments; go RUN if k was NUM_RKEYS-1, else KEY_WAIT.
REQ-017 Key index k SHALL be 4 bits, reset 0, cleared on entry to RUN; addresses 0..21 only.
REQ-018 RUN: keys_loaded=1, key_ready=1 only while tag FIFO empty and no core_in_en pending; key_valid&key_ready then captures key 0, clears keys_loaded, goes KEY_WR_LO (reload).
REQ-019 reqN_ready SHALL be 1 only in RUN, tag FIFO not full, and channel N granted by arbiter.
REQ-020 Arbiter round-robin: both valid -> grant channel not granted last; one valid -> grant it; at most one accept per cycle.
REQ-021 Last-grant pointer resets to 1 so channel 0 wins the first contention.
REQ-022 Accept in cycle N -> core_in_data=accepted block, core_in_en=1 in cycle N+1 (registered); tag (channel id) pushed in cycle N.
REQ-023 core_out_en in cycle M -> pop tag; rsp<tag>_data=core_out_data, rsp<tag>_valid=1 in cycle M+1; other rsp_valid=0.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; full FIFO with same-cycle pop still blocks grant (no bypass).
REQ-025 core_out_en with empty FIFO SHALL set err_unexp (sticky until kill) and drop the result.
REQ-026 busy SHALL equal (state != RUN) or FIFO not empty or core_in_en.
REQ-027 Key stream stalls (key_valid low) SHALL hold state indefinitely without writes.

Reset
REQ-028 On kill: state=KEY_WAIT, k=0, FIFO empty, pointer=1, all valid/enable outputs 0, data outputs 0, keys_loaded=0, err_unexp=0, busy=1.
REQ-029 kill mid-load or mid-traffic SHALL discard captured key, tags and pending strobes; no output strobe in the cycle after release.

Verification
REQ-030 11 keys back-to-back -> 22 writes, addr 0..21 in order, lo/hi halves correct, keys_loaded rises after addr 21 write.
REQ-031 Both channels valid continuously in RUN -> grants alternate 0,1,0,1; core_in_en each accept+1 cycle.
REQ-032 16 accepts with no core_out_en -> reqN_ready low; one core_out_en -> rsp on issued channel next cycle, grant resumes the cycle after.
REQ-033 core_out_en with empty FIFO -> err_unexp=1, no rsp_valid, err held until kill.
REQ-034 key_valid in RUN with 2 blocks in flight -> key_ready=0 until both results returned, then reload from addr 0.
REQ-035 kill asserted during KEY_WR_HI of key 5 -> no write next cycle, keys_loaded=0, next key written to addr 0.

Source files
------------

// File: rtl/aes_128_sched.sv
// aes_128_sched: round-key loader and two-channel block scheduler for an
// external AES-128 core.
//   clk, kill                          clock, async active-high reset
//   key_in/key_valid/key_ready         round-key stream, written to key RAM as
//                                      two 64-bit halves per key
//   req0_*/req1_*                      per-channel plaintext requests
//   core_in_data/core_in_en            block issue to the core (registered)
//   core_en_wr/core_addr_wr/core_key_wr key RAM write port
//   core_out_data/core_out_en          core results, returned in issue order
//   rsp0_*/rsp1_*                      per-channel routed results
//   keys_loaded/busy/err_unexp         status
module aes_128_sched #(
  parameter int TAG_DEPTH = 16,
  parameter int NUM_RKEYS = 11
) (
  input  logic         clk,
  input  logic         kill,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] req0_data,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req1_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  output logic [127:0] core_in_data,
  output logic         core_in_en,
  output logic         core_en_wr,
  output logic [4:0]   core_addr_wr,
  output logic [63:0]  core_key_wr,
  input  logic [127:0] core_out_data,
  input  logic         core_out_en,
  output logic [127:0] rsp0_data,
  output logic         rsp0_valid,
  output logic [127:0] rsp1_data,
  output logic         rsp1_valid,
  output logic         keys_loaded,
  output logic         busy,
  output logic         err_unexp
);
  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {KEY_WAIT, KEY_WR_LO, KEY_WR_HI, RUN} state_t;

  state_t         state, state_nxt;
  logic [3:0]     k;
  logic [127:0]   key_q;
  logic           key_fire;
  logic           last_key;

  // tag FIFO: one bit per in-flight block, the channel that issued it
  logic           tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    cnt;
  logic           tag_empty, tag_full, pop, pop_tag;

  logic           last_gnt;
  logic           gnt0, gnt1, acc0, acc1, accept, run;

  assign run       = (state == RUN);
  assign last_key  = (k == 4'(NUM_RKEYS - 1));
  assign key_fire  = key_valid & key_ready;
  assign tag_empty = (cnt == '0);
  assign tag_full  = (cnt == (PW+1)'(TAG_DEPTH));
  assign pop       = core_out_en & ~tag_empty;
  assign pop_tag   = tag_mem[rd_ptr];

  // Round robin: on contention the channel not granted last wins.
  // last_gnt resets to 1 so channel 0 takes the first contention.
  assign gnt0 = req0_valid & (~req1_valid | last_gnt);
  assign gnt1 = req1_valid & (~req0_valid | ~last_gnt);

  // A full FIFO blocks grant even with a same-cycle pop (no bypass path).
  assign req0_ready = run & ~tag_full & gnt0;
  assign req1_ready = run & ~tag_full & gnt1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign accept     = acc0 | acc1;

  assign keys_loaded = run;
  assign busy        = ~run | ~tag_empty | core_in_en;

  always_comb begin
    state_nxt    = state;
    key_ready    = 1'b0;
    core_en_wr   = 1'b0;
    core_addr_wr = '0;
    core_key_wr  = '0;
    case (state)
      KEY_WAIT: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = KEY_WR_LO;
      end
      KEY_WR_LO: begin
        core_en_wr   = 1'b1;
        core_addr_wr = {k, 1'b0};
        core_key_wr  = key_q[63:0];
        state_nxt    = KEY_WR_HI;
      end
      KEY_WR_HI: begin
        core_en_wr   = 1'b1;
        core_addr_wr = {k, 1'b1};
        core_key_wr  = key_q[127:64];
        state_nxt    = last_key ? RUN : KEY_WAIT;
      end
      RUN: begin
        // reload only once the datapath is drained, so no block sees a
        // half-rewritten schedule
        key_ready = tag_empty & ~core_in_en;
        if (key_valid & key_ready) state_nxt = KEY_WR_LO;
      end
      default: state_nxt = KEY_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state <= KEY_WAIT;
      k     <= '0;
      key_q <= '0;
    end else begin
      state <= state_nxt;
      if (key_fire) key_q <= key_in;
      if (state == KEY_WR_HI) k <= last_key ? 4'd0 : k + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= acc1;
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_gnt <= acc1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      core_in_en   <= 1'b0;
      core_in_data <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
      err_unexp    <= 1'b0;
    end else begin
      core_in_en <= accept;
      if (accept) core_in_data <= acc1 ? req1_data : req0_data;
      rsp0_valid <= pop & ~pop_tag;
      rsp1_valid <= pop & pop_tag;
      if (pop & ~pop_tag) rsp0_data <= core_out_data;
      if (pop & pop_tag)  rsp1_data <= core_out_data;
      // a result with nothing outstanding is dropped and flagged
      if (core_out_en & tag_empty) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_128_sched.sv
// Self-checking bench for aes_128_sched. The bench plays the AES core: every
// issued block is queued and later returned XORed with MASK. Expected key
// writes, issues and responses are queued when stimulus is driven and
// popped by a negedge monitor when the DUT produces them.
module tb_aes_128_sched;
  localparam logic [127:0] MASK = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic         clk = 1'b0;
  logic         kill;
  logic [127:0] key_in, req0_data, req1_data, core_out_data;
  logic         key_valid, req0_valid, req1_valid, core_out_en;
  logic         key_ready, req0_ready, req1_ready;
  logic [127:0] core_in_data, rsp0_data, rsp1_data;
  logic         core_in_en, core_en_wr, rsp0_valid, rsp1_valid;
  logic [4:0]   core_addr_wr;
  logic [63:0]  core_key_wr;
  logic         keys_loaded, busy, err_unexp;

  always #5 clk = ~clk;

  aes_128_sched #(.TAG_DEPTH(16), .NUM_RKEYS(11)) dut (
    .clk(clk), .kill(kill),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .core_in_data(core_in_data), .core_in_en(core_in_en),
    .core_en_wr(core_en_wr), .core_addr_wr(core_addr_wr), .core_key_wr(core_key_wr),
    .core_out_data(core_out_data), .core_out_en(core_out_en),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid),
    .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid),
    .keys_loaded(keys_loaded), .busy(busy), .err_unexp(err_unexp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int kidx    = 0;

  logic [68:0]  exp_wr[$];    // {addr, 64-bit half}
  logic [127:0] exp_cin[$];
  int           exp_cin_cyc[$];
  logic [128:0] exp_rsp[$];   // {channel, data}
  logic [127:0] core_q[$];
  int           ret_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // monitor: registered/state-only outputs, stable at negedge
  always @(negedge clk) begin
    logic [68:0]  w;
    logic [128:0] r;
    if (core_en_wr) begin
      if (exp_wr.size() == 0) chk("wr_unexp", 128'(core_en_wr), 128'(0));
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 128'(core_addr_wr), 128'(w[68:64]));
        chk("wr_data", 128'(core_key_wr), 128'(w[63:0]));
      end
    end
    if (core_in_en) begin
      if (exp_cin.size() == 0) chk("cin_unexp", 128'(core_in_en), 128'(0));
      else begin
        chk("cin_data", core_in_data, exp_cin.pop_front());
        chk("cin_lat", 128'(cyc), 128'(exp_cin_cyc.pop_front() + 1));
        core_q.push_back(core_in_data);
      end
    end
    if (rsp0_valid || rsp1_valid) begin
      chk("rsp_one", 128'(rsp0_valid & rsp1_valid), 128'(0));
      if (exp_rsp.size() == 0) chk("rsp_unexp", 128'(rsp0_valid | rsp1_valid), 128'(0));
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_ch", 128'(rsp1_valid), 128'(r[128]));
        chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, r[127:0]);
        if (ret_cyc.size() > 0) chk("rsp_lat", 128'(cyc), 128'(ret_cyc.pop_front() + 1));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [127:0] kv);
    int n = 0;
    key_in = kv; key_valid = 1'b1;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      step(); @(negedge clk); n++;
    end
    if (!key_ready) chk("key_timeout", 128'(key_ready), 128'(1));
    else begin
      exp_wr.push_back({5'(2*kidx), kv[63:0]});
      exp_wr.push_back({5'(2*kidx+1), kv[127:64]});
      kidx = (kidx == 10) ? 0 : kidx + 1;
    end
    step();
    key_valid = 1'b0; key_in = '0;
  endtask

  // full schedule with random stalls; ends in RUN
  task automatic load_all(input int first);
    for (int i = first; i < 11; i++) begin
      repeat ($urandom_range(0, 2)) step();
      load_key(rnd128());
    end
    chk("kl_before_hi", 128'(keys_loaded), 128'(0));
    step(); step();
    chk("kl_after_21", 128'(keys_loaded), 128'(1));
    chk("wr_left", 128'(exp_wr.size()), 128'(0));
  endtask

  task automatic send(input logic v0, input logic v1, output int ch);
    logic [127:0] d0, d1;
    d0 = rnd128(); d1 = rnd128();
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    @(negedge clk);
    chk("one_acc", 128'((req0_valid & req0_ready) & (req1_valid & req1_ready)), 128'(0));
    ch = -1;
    if (req0_valid && req0_ready) ch = 0;
    else if (req1_valid && req1_ready) ch = 1;
    if (ch >= 0) begin
      exp_cin.push_back(ch ? d1 : d0);
      exp_cin_cyc.push_back(cyc);
      exp_rsp.push_back({ch[0], (ch ? d1 : d0) ^ MASK});
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic core_ret();
    if (core_q.size() == 0) chk("core_q_empty", 128'(core_q.size()), 128'(1));
    else begin
      core_out_data = core_q.pop_front() ^ MASK;
      core_out_en = 1'b1;
      @(negedge clk);
      ret_cyc.push_back(cyc);
      step();
      core_out_en = 1'b0;
    end
  endtask

  task automatic do_kill();
    kill = 1'b1;
    exp_wr.delete(); exp_cin.delete(); exp_cin_cyc.delete();
    exp_rsp.delete(); core_q.delete(); ret_cyc.delete();
    kidx = 0;
    @(negedge clk);
    chk("kill_wr", 128'(core_en_wr), 128'(0));
    chk("kill_kl", 128'(keys_loaded), 128'(0));
    chk("kill_err", 128'(err_unexp), 128'(0));
    chk("kill_busy", 128'(busy), 128'(1));
    chk("kill_cin", 128'(core_in_en), 128'(0));
    step();
    kill = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ch;
    logic [127:0] d;
    kill = 1'b1; key_in = '0; key_valid = 1'b0;
    req0_data = '0; req0_valid = 1'b0; req1_data = '0; req1_valid = 1'b0;
    core_out_data = '0; core_out_en = 1'b0;
    @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_kl", 128'(keys_loaded), 128'(0));
    chk("rst_busy", 128'(busy), 128'(1));
    chk("rst_err", 128'(err_unexp), 128'(0));
    chk("rst_wr", 128'(core_en_wr), 128'(0));
    chk("rst_cin", {127'd0, core_in_en}, 128'(0));
    chk("rst_cin_data", core_in_data, 128'(0));
    chk("rst_rsp", 128'({rsp0_valid, rsp1_valid}), 128'(0));
    chk("rst_rsp_data", rsp0_data | rsp1_data, 128'(0));
    chk("rst_rdy", 128'({req0_ready, req1_ready}), 128'(0));
    step();
    kill = 1'b0;
    step();

    // full key schedule with stalls
    load_all(0);
    chk("idle_busy", 128'(busy), 128'(0));

    // contention alternates starting with channel 0
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1, ch);
      chk("alt_grant", 128'(ch), 128'(i % 2));
    end
    step();
    for (int i = 0; i < 8; i++) core_ret();
    step(); step();
    chk("alt_rsp_left", 128'(exp_rsp.size()), 128'(0));

    // fill the tag FIFO, then no-bypass and resume
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b0, ch);
      chk("fill_grant", 128'(ch), 128'(0));
    end
    d = rnd128();
    req0_valid = 1'b1; req0_data = d;
    @(negedge clk);
    chk("full_rdy", 128'(req0_ready), 128'(0));
    step();
    core_out_data = core_q.pop_front() ^ MASK;
    core_out_en = 1'b1;
    @(negedge clk);
    chk("full_pop_rdy", 128'(req0_ready), 128'(0));
    ret_cyc.push_back(cyc);
    step();
    core_out_en = 1'b0;
    @(negedge clk);
    chk("resume_rdy", 128'(req0_ready), 128'(1));
    if (req0_ready) begin
      exp_cin.push_back(d); exp_cin_cyc.push_back(cyc);
      exp_rsp.push_back({1'b0, d ^ MASK});
    end
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) core_ret();
    step(); step();
    chk("fill_rsp_left", 128'(exp_rsp.size()), 128'(0));
    chk("drain_busy", 128'(busy), 128'(0));

    // reload held off while blocks are in flight
    send(1'b0, 1'b1, ch);
    chk("rl_grant1", 128'(ch), 128'(1));
    send(1'b1, 1'b0, ch);
    chk("rl_grant0", 128'(ch), 128'(0));
    key_valid = 1'b1; key_in = '0;
    @(negedge clk);
    chk("rl_rdy_2", 128'(key_ready), 128'(0));
    step();
    core_ret();
    @(negedge clk);
    chk("rl_rdy_1", 128'(key_ready), 128'(0));
    chk("rl_kl", 128'(keys_loaded), 128'(1));
    step();
    core_ret();
    load_key(rnd128());   // must land at addr 0/1
    load_all(1);
    chk("rl_rsp_left", 128'(exp_rsp.size()), 128'(0));

    // unexpected result with nothing in flight
    core_out_data = rnd128(); core_out_en = 1'b1;
    step();
    core_out_en = 1'b0;
    @(negedge clk);
    chk("err_set", 128'(err_unexp), 128'(1));
    repeat (3) step();
    chk("err_held", 128'(err_unexp), 128'(1));

    // kill with an issue strobe pending: it must vanish
    send(1'b1, 1'b0, ch);
    do_kill();
    chk("post_kill_cin", 128'(core_in_en), 128'(0));

    // kill during the high-half write of key 5
    for (int i = 0; i < 5; i++) load_key(rnd128());
    load_key(rnd128());
    step();
    do_kill();
    load_key(rnd128());
    step(); step();
    chk("after_kill_wr_left", 128'(exp_wr.size()), 128'(0));
    chk("after_kill_kl", 128'(keys_loaded), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
